slot2_rom_responder: RTL and testbench

Cartridge-side responder for the slot-2 multiplexed ROM bus. It sits directly downstream of the bus-timing stimulus: it consumes ncs/nrd/nwr and the 16-bit AD bus, and latches the low address on ncs fall. It prefetches the halfword from a memory port, drives it during nrd low, and auto-increments on each nrd/nwr rising edge. Bus inputs are asynchronous and are oversampled by the system clock (≥100 MHz for a 59.6 ns phi).

---
 rtl/slot2_rom_responder_if.sv | 32 +++
 rtl/slot2_rom_responder.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_slot2_rom_responder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot2_rom_responder_if.sv
// Slot-2 ROM bus bundle: multiplexed AD bus strobes, memory read port and
// write-out port of the cartridge responder. The slave side is the responder,
// the master side is whoever drives the bus and serves the memory port.
interface slot2_rom_responder_if;
  logic        ncs;
  logic        nrd;
  logic        nwr;
  logic [7:0]  a_hi;
  logic [15:0] ad_in;
  logic [15:0] ad_out;
  logic        ad_oe;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        wr_valid;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_underrun;

  modport slave (
    input  ncs, nrd, nwr, a_hi, ad_in, mem_ready, mem_rdata,
    output ad_out, ad_oe, mem_req, mem_addr, wr_valid, wr_addr, wr_data,
           rd_underrun
  );

  modport master (
    output ncs, nrd, nwr, a_hi, ad_in, mem_ready, mem_rdata,
    input  ad_out, ad_oe, mem_req, mem_addr, wr_valid, wr_addr, wr_data,
           rd_underrun
  );
endinterface

// File: rtl/slot2_rom_responder.sv
// Cartridge-side responder for the slot-2 multiplexed ROM bus. The bus is
// asynchronous to clk: strobes and the AD/A_hi buses are oversampled through
// equal-depth synchronizer chains so data stays aligned with its strobe.
// A halfword is prefetched from the memory port after each address latch or
// increment so it is ready to drive as soon as nrd falls.
module slot2_rom_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  slot2_rom_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DRIVE,
    ST_DRIVE_WAIT,
    ST_WRITE,
    ST_ABORT
  } state_t;

  // Synchronizer chains; index SYNC_STAGES-1 is the usable sample.
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic [SYNC_STAGES-1:0] nrd_sync_q;
  logic [SYNC_STAGES-1:0] nwr_sync_q;
  logic [15:0]            ad_sync_q  [SYNC_STAGES];
  logic [7:0]             ahi_sync_q [SYNC_STAGES];

  // Previous synchronized strobe samples for edge detection.
  logic ncs_prev_q;
  logic nrd_prev_q;
  logic nwr_prev_q;

  logic        s_ncs;
  logic        s_nrd;
  logic        s_nwr;
  logic [15:0] s_ad;
  logic [7:0]  s_ahi;

  logic ncs_fall;
  logic ncs_rise;
  logic nrd_fall;
  logic nrd_rise;
  logic nwr_fall;
  logic nwr_rise;

  // Control / output registers.
  state_t      state_q;
  logic [15:0] addr_q;
  logic [7:0]  hi_q;
  logic [15:0] pf_q;
  logic        pf_valid_q;
  logic [15:0] wdat_q;
  logic        pend_q;
  logic [15:0] ad_out_q;
  logic        ad_oe_q;
  logic        mem_req_q;
  logic [23:0] mem_addr_q;
  logic        wr_valid_q;
  logic [23:0] wr_addr_q;
  logic [15:0] wr_data_q;
  logic        rd_underrun_q;

  logic [15:0] addr_inc_d;

  assign s_ncs = ncs_sync_q[SYNC_STAGES-1];
  assign s_nrd = nrd_sync_q[SYNC_STAGES-1];
  assign s_nwr = nwr_sync_q[SYNC_STAGES-1];
  assign s_ad  = ad_sync_q[SYNC_STAGES-1];
  assign s_ahi = ahi_sync_q[SYNC_STAGES-1];

  assign ncs_fall = ncs_prev_q & ~s_ncs;
  assign ncs_rise = ~ncs_prev_q & s_ncs;
  assign nrd_fall = nrd_prev_q & ~s_nrd;
  assign nrd_rise = ~nrd_prev_q & s_nrd;
  assign nwr_fall = nwr_prev_q & ~s_nwr;
  assign nwr_rise = ~nwr_prev_q & s_nwr;

  // 16-bit counter wraps naturally; no carry into the high address byte.
  assign addr_inc_d = addr_q + 16'd1;

  // Oversample the asynchronous bus and keep one previous strobe sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_sync_q <= '1;
      nrd_sync_q <= '1;
      nwr_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ad_sync_q[i]  <= '0;
        ahi_sync_q[i] <= '0;
      end
      ncs_prev_q <= 1'b1;
      nrd_prev_q <= 1'b1;
      nwr_prev_q <= 1'b1;
    end else begin
      ncs_sync_q    <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
      nrd_sync_q    <= {nrd_sync_q[SYNC_STAGES-2:0], bus.nrd};
      nwr_sync_q    <= {nwr_sync_q[SYNC_STAGES-2:0], bus.nwr};
      ad_sync_q[0]  <= bus.ad_in;
      ahi_sync_q[0] <= bus.a_hi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ad_sync_q[i]  <= ad_sync_q[i-1];
        ahi_sync_q[i] <= ahi_sync_q[i-1];
      end
      ncs_prev_q <= s_ncs;
      nrd_prev_q <= s_nrd;
      nwr_prev_q <= s_nwr;
    end
  end

  // Responder FSM with registered bus, memory and write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      hi_q          <= '0;
      pf_q          <= '0;
      pf_valid_q    <= 1'b0;
      wdat_q        <= '0;
      pend_q        <= 1'b0;
      ad_out_q      <= '0;
      ad_oe_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_underrun_q <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;

      if (state_q != ST_IDLE && state_q != ST_ABORT && ncs_rise) begin
        // Chip select released: stop driving, clear the underrun flag and
        // drain any outstanding read before going idle. A strobe rise in the
        // same cycle still bumps the counter, which is harmless.
        ad_oe_q       <= 1'b0;
        rd_underrun_q <= 1'b0;
        pf_valid_q    <= 1'b0;
        pend_q        <= 1'b0;
        if (nrd_rise || nwr_rise) begin
          addr_q <= addr_inc_d;
        end
        if (mem_req_q && !bus.mem_ready) begin
          state_q <= ST_ABORT;
        end else begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            ad_oe_q <= 1'b0;
            if (ncs_fall) begin
              addr_q     <= s_ad;
              hi_q       <= s_ahi;
              mem_addr_q <= {s_ahi, s_ad};
              mem_req_q  <= 1'b1;
              pf_valid_q <= 1'b0;
              state_q    <= ST_FETCH;
            end
          end

          ST_FETCH: begin
            if (bus.mem_ready) begin
              pf_q       <= bus.mem_rdata;
              pf_valid_q <= 1'b1;
              mem_req_q  <= 1'b0;
              if (nrd_fall) begin
                // Data landed in the same cycle the read started.
                ad_oe_q  <= 1'b1;
                ad_out_q <= bus.mem_rdata;
                state_q  <= ST_DRIVE;
              end else begin
                state_q <= ST_HOLD;
              end
            end else if (nrd_fall) begin
              rd_underrun_q <= 1'b1;
              ad_oe_q       <= 1'b1;
              ad_out_q      <= 16'h0000;
              state_q       <= ST_DRIVE_WAIT;
            end
          end

          ST_HOLD: begin
            if (nrd_fall && pf_valid_q) begin
              ad_oe_q  <= 1'b1;
              ad_out_q <= pf_q;
              state_q  <= ST_DRIVE;
            end else if (nwr_fall) begin
              wdat_q  <= s_ad;
              state_q <= ST_WRITE;
            end
          end

          ST_DRIVE: begin
            if (nrd_rise) begin
              ad_oe_q    <= 1'b0;
              addr_q     <= addr_inc_d;
              mem_addr_q <= {hi_q, addr_inc_d};
              mem_req_q  <= 1'b1;
              pf_valid_q <= 1'b0;
              state_q    <= ST_FETCH;
            end
          end

          ST_DRIVE_WAIT: begin
            if (bus.mem_ready) begin
              pf_q       <= bus.mem_rdata;
              pf_valid_q <= 1'b1;
              ad_out_q   <= bus.mem_rdata;
              if (nrd_rise) begin
                // Read ended as the data arrived: move straight on.
                ad_oe_q    <= 1'b0;
                addr_q     <= addr_inc_d;
                mem_addr_q <= {hi_q, addr_inc_d};
                mem_req_q  <= 1'b1;
                pf_valid_q <= 1'b0;
                state_q    <= ST_FETCH;
              end else begin
                mem_req_q <= 1'b0;
                state_q   <= ST_DRIVE;
              end
            end else if (nrd_rise) begin
              // Host gave up before data came back: drain the stale reply,
              // then refetch at the incremented address.
              ad_oe_q <= 1'b0;
              addr_q  <= addr_inc_d;
              pend_q  <= 1'b1;
              state_q <= ST_ABORT;
            end
          end

          ST_WRITE: begin
            if (!s_nwr) begin
              wdat_q <= s_ad;
            end
            if (nwr_rise) begin
              wr_valid_q <= 1'b1;
              wr_addr_q  <= {hi_q, addr_q};
              wr_data_q  <= wdat_q;
              addr_q     <= addr_inc_d;
              mem_addr_q <= {hi_q, addr_inc_d};
              mem_req_q  <= 1'b1;
              pf_valid_q <= 1'b0;
              state_q    <= ST_FETCH;
            end
          end

          ST_ABORT: begin
            // mem_req and mem_addr stay frozen until the reply is drained;
            // a new select only updates the internal address.
            ad_oe_q <= 1'b0;
            if (ncs_fall) begin
              addr_q <= s_ad;
              hi_q   <= s_ahi;
            end
            if (bus.mem_ready) begin
              pend_q <= 1'b0;
              if (ncs_fall) begin
                mem_addr_q <= {s_ahi, s_ad};
                state_q    <= ST_FETCH;
              end else if (pend_q && !ncs_rise) begin
                mem_addr_q <= {hi_q, addr_q};
                state_q    <= ST_FETCH;
              end else begin
                mem_req_q <= 1'b0;
                state_q   <= ST_IDLE;
              end
            end else if (ncs_fall) begin
              pend_q <= 1'b1;
            end else if (ncs_rise) begin
              pend_q <= 1'b0;
            end
          end

          default: begin
            ad_oe_q   <= 1'b0;
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ad_out      = ad_out_q;
  assign bus.ad_oe       = ad_oe_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.wr_valid    = wr_valid_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.rd_underrun = rd_underrun_q;

endmodule

// File: tb/tb_slot2_rom_responder.sv
// Bench for slot2_rom_responder: directed bus transactions, a latency-driven
// memory responder, and a transaction-level model (address counter, request
// and write queues) checked every cycle, plus literal spot checks.
module tb_slot2_rom_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slot2_rom_responder_if bus ();

  slot2_rom_responder #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model state
  logic [15:0] m_addr;
  logic [7:0]  m_hi;
  logic [23:0] req_q [$];
  logic [39:0] wr_q  [$];
  logic [15:0] exp_rd;
  bit          allow_zero;
  logic [23:0] last_req;
  int          lat;

  function automatic logic [15:0] memf(input logic [23:0] a);
    if (a == 24'h08ADD8) return 16'hDA7A;
    return a[15:0] ^ {a[23:16], 8'hC3} ^ 16'h1357;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ncs_open(input logic [15:0] ad, input logic [7:0] hi);
    bus.ad_in = ad;
    bus.a_hi  = hi;
    bus.ncs   = 1'b0;
    m_addr    = ad;
    m_hi      = hi;
    req_q.push_back({hi, ad});
  endtask

  task automatic do_read(input int low, input int gap);
    bus.nrd = 1'b0;
    exp_rd  = memf({m_hi, m_addr});
    cyc(low);
    bus.nrd = 1'b1;
    m_addr  = m_addr + 16'd1;
    req_q.push_back({m_hi, m_addr});
    cyc(gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ad_oe"},    bus.ad_oe, 0);
    check({tag, "_ad_out"},   bus.ad_out, 0);
    check({tag, "_mem_req"},  bus.mem_req, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_wr_valid"}, bus.wr_valid, 0);
    check({tag, "_wr_addr"},  bus.wr_addr, 0);
    check({tag, "_wr_data"},  bus.wr_data, 0);
    check({tag, "_underrun"}, bus.rd_underrun, 0);
  endtask

  // Memory responder: answers each request after lat cycles.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        cnt = 0;
      end else if (bus.mem_req && !rst) begin
        cnt++;
        if (cnt >= lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = memf(bus.mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Per-cycle compare against the transaction model.
  initial begin
    logic        prev_req;
    logic        prev_ready;
    logic [23:0] prev_addr;
    int          nrd_hi_cnt;
    int          ncs_hi_cnt;
    logic [39:0] wexp;
    prev_req = 1'b0; prev_ready = 1'b0; prev_addr = '0;
    nrd_hi_cnt = 0; ncs_hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_req && (!prev_req || prev_ready)) begin
          last_req = bus.mem_addr;
          if (req_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL req_unexpected: got %h expected no request", bus.mem_addr);
          end else begin
            check("req_addr", bus.mem_addr, req_q.pop_front());
          end
        end else if (bus.mem_req) begin
          check("req_addr_stable", bus.mem_addr, prev_addr);
        end
        if (bus.ad_oe && !(allow_zero && bus.ad_out == 16'h0000)) begin
          check("ad_out_data", bus.ad_out, exp_rd);
        end
        if (nrd_hi_cnt >= 4 || ncs_hi_cnt >= 4) begin
          check("ad_oe_released", bus.ad_oe, 0);
        end
        if (bus.wr_valid) begin
          if (wr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_unexpected: got %h/%h expected no write", bus.wr_addr, bus.wr_data);
          end else begin
            wexp = wr_q.pop_front();
            check("wr_beat", {bus.wr_addr, bus.wr_data}, wexp);
          end
        end
      end
      prev_req   = bus.mem_req;
      prev_ready = bus.mem_ready;
      prev_addr  = bus.mem_addr;
      nrd_hi_cnt = bus.nrd ? ((nrd_hi_cnt < 100) ? nrd_hi_cnt + 1 : 100) : 0;
      ncs_hi_cnt = bus.ncs ? ((ncs_hi_cnt < 100) ? ncs_hi_cnt + 1 : 100) : 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100us");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    rst = 1'b1;
    bus.ncs = 1'b1; bus.nrd = 1'b1; bus.nwr = 1'b1;
    bus.a_hi = 8'h00; bus.ad_in = 16'h0000;
    m_addr = '0; m_hi = '0; exp_rd = '0; allow_zero = 1'b0; last_req = '0;
    lat = 1;
    cyc(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc(3);

    // Single read with 3-cycle memory latency
    lat = 3;
    ncs_open(16'hADD8, 8'h08);
    cyc(2);
    check("ncs_to_req_early", bus.mem_req, 0);
    cyc(1);
    check("ncs_to_req", bus.mem_req, 1);
    check("req_addr_lit", bus.mem_addr, 24'h08ADD8);
    cyc(2);
    check("req_held", bus.mem_req, 1);
    cyc(1);
    check("req_dropped", bus.mem_req, 0);
    cyc(3);
    bus.nrd = 1'b0;
    exp_rd  = memf({m_hi, m_addr});
    cyc(2);
    check("nrd_to_oe_early", bus.ad_oe, 0);
    cyc(1);
    check("nrd_to_oe", bus.ad_oe, 1);
    check("rd_data_lit", bus.ad_out, 16'hDA7A);
    cyc(3);
    bus.nrd = 1'b1;
    m_addr  = m_addr + 16'd1;
    req_q.push_back({m_hi, m_addr});
    cyc(3);
    check("oe_release", bus.ad_oe, 0);
    cyc(5);

    // Sequential reads, then ncs and nrd rising together
    check("seq_addr_lit", last_req, 24'h08ADD9);
    do_read(6, 10);
    check("seq_addr2_lit", last_req, 24'h08ADDA);
    bus.nrd = 1'b0;
    exp_rd  = memf({m_hi, m_addr});
    cyc(6);
    bus.nrd = 1'b1;
    bus.ncs = 1'b1;
    m_addr  = m_addr + 16'd1;
    cyc(4);
    check("simul_rise_oe", bus.ad_oe, 0);
    check("simul_rise_req", bus.mem_req, 0);
    cyc(4);

    // Address wrap
    lat = 1;
    ncs_open(16'hFFFF, 8'h12);
    cyc(8);
    check("wrap_first_lit", last_req, 24'h12FFFF);
    do_read(6, 8);
    check("wrap_second_lit", last_req, 24'h120000);
    do_read(6, 8);
    bus.ncs = 1'b1;
    cyc(6);

    // Underrun: read starts long before the prefetch returns
    lat = 20;
    allow_zero = 1'b1;
    ncs_open(16'h2000, 8'h21);
    cyc(4);
    bus.nrd = 1'b0;
    exp_rd  = memf({m_hi, m_addr});
    cyc(5);
    check("underrun_flag", bus.rd_underrun, 1);
    check("underrun_oe", bus.ad_oe, 1);
    check("underrun_zero", bus.ad_out, 16'h0000);
    cyc(20);
    check("underrun_data_lit", bus.ad_out, 16'h1294);
    check("underrun_sticky", bus.rd_underrun, 1);
    bus.nrd = 1'b1;
    m_addr  = m_addr + 16'd1;
    req_q.push_back({m_hi, m_addr});
    cyc(6);
    bus.ncs = 1'b1;
    cyc(4);
    check("underrun_clear", bus.rd_underrun, 0);
    check("underrun_abort_oe", bus.ad_oe, 0);
    check("underrun_abort_req", bus.mem_req, 1);
    cyc(25);
    check("underrun_abort_done", bus.mem_req, 0);
    allow_zero = 1'b0;
    lat = 1;

    // Write, then a read at the incremented address
    ncs_open(16'h0100, 8'h08);
    cyc(8);
    bus.ad_in = 16'h1111;
    bus.nwr = 1'b0;
    cyc(2);
    bus.ad_in = 16'hBEEF;
    cyc(3);
    bus.nwr = 1'b1;
    wr_q.push_back({m_hi, m_addr, 16'hBEEF});
    m_addr = m_addr + 16'd1;
    req_q.push_back({m_hi, m_addr});
    cyc(2);
    check("wr_valid_early", bus.wr_valid, 0);
    cyc(1);
    check("wr_valid", bus.wr_valid, 1);
    check("wr_addr_lit", bus.wr_addr, 24'h080100);
    check("wr_data_lit", bus.wr_data, 16'hBEEF);
    cyc(1);
    check("wr_valid_pulse", bus.wr_valid, 0);
    cyc(4);
    check("post_wr_addr_lit", last_req, 24'h080101);
    do_read(6, 8);
    bus.ncs = 1'b1;
    cyc(6);

    // Abort: ncs rises while the fetch is outstanding
    lat = 15;
    ncs_open(16'h4000, 8'h33);
    cyc(5);
    bus.ncs = 1'b1;
    cyc(4);
    check("abort_req_held", bus.mem_req, 1);
    check("abort_addr_lit", bus.mem_addr, 24'h334000);
    cyc(20);
    check("abort_idle_req", bus.mem_req, 0);
    check("abort_idle_oe", bus.ad_oe, 0);

    // New select during abort: refetch at the new address after drain
    ncs_open(16'h5000, 8'h44);
    cyc(5);
    bus.ncs = 1'b1;
    cyc(4);
    ncs_open(16'h6000, 8'h44);
    cyc(4);
    lat = 1;
    cyc(10);
    check("relatch_addr_lit", last_req, 24'h446000);
    do_read(6, 8);
    bus.ncs = 1'b1;
    cyc(6);

    // Reset asserted mid-drive
    ncs_open(16'h7000, 8'h55);
    cyc(8);
    bus.nrd = 1'b0;
    exp_rd  = memf({m_hi, m_addr});
    cyc(5);
    check("pre_reset_oe", bus.ad_oe, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    bus.nrd = 1'b1;
    bus.ncs = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(6);
    check("post_reset_req", bus.mem_req, 0);
    check("post_reset_oe", bus.ad_oe, 0);

    check("req_queue_drained", req_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
